// File: rtl/pcs_sync.sv
// Receive-side code-group synchronisation for a 1000BASE-X style PCS.
// Qualifies incoming 10-bit groups, tracks comma alignment and reports link sync status.
module pcs_sync #(
    parameter int unsigned GOOD_CGS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        signal_detect,
    input  logic [9:0]  rx_code_group,
    output logic [9:0]  cg_out,
    output logic        sync_status,
    output logic        rx_even,
    output logic [12:0] sync_state
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC     = 4'd0,
        COMMA_DETECT_1   = 4'd1,
        ACQUIRE_SYNC_1   = 4'd2,
        COMMA_DETECT_2   = 4'd3,
        ACQUIRE_SYNC_2   = 4'd4,
        COMMA_DETECT_3   = 4'd5,
        SYNC_ACQUIRED_1  = 4'd6,
        SYNC_ACQUIRED_2  = 4'd7,
        SYNC_ACQUIRED_2A = 4'd8,
        SYNC_ACQUIRED_3  = 4'd9,
        SYNC_ACQUIRED_3A = 4'd10,
        SYNC_ACQUIRED_4  = 4'd11,
        SYNC_ACQUIRED_4A = 4'd12
    } state_t;

    localparam logic [1:0] LIMIT = 2'(GOOD_CGS_LIMIT);

    // Codes are written abcdei_fghj with bit a in position 9.
    function automatic logic is_comma(input logic [9:0] cg);
        case (cg)
            10'b001111_1001, 10'b110000_0110,
            10'b001111_1010, 10'b110000_0101,
            10'b001111_1000, 10'b110000_0111: is_comma = 1'b1;
            default:                          is_comma = 1'b0;
        endcase
    endfunction

    function automatic logic is_data(input logic [9:0] cg);
        case (cg)
            10'b100111_0100, 10'b011000_1011,
            10'b011101_0100, 10'b100010_1011,
            10'b101101_0100, 10'b010010_1011,
            10'b110001_1011, 10'b110001_0100,
            10'b101101_0101, 10'b010010_0101,
            10'b011011_0101, 10'b100100_0101,
            10'b010110_1101, 10'b010110_0010,
            10'b011001_1010, 10'b101010_1010,
            10'b101001_0110:                  is_data = 1'b1;
            default:                          is_data = 1'b0;
        endcase
    endfunction

    function automatic logic is_special(input logic [9:0] cg);
        case (cg)
            10'b001111_0100, 10'b110000_1011,
            10'b001111_1001, 10'b110000_0110,
            10'b001111_0101, 10'b110000_1010,
            10'b001111_0011, 10'b110000_1100,
            10'b001111_0010, 10'b110000_1101,
            10'b001111_1010, 10'b110000_0101,
            10'b001111_0110, 10'b110000_1001,
            10'b001111_1000, 10'b110000_0111,
            10'b111010_1000, 10'b000101_0111,
            10'b110110_1000, 10'b001001_0111,
            10'b101110_1000, 10'b010001_0111,
            10'b011110_1000, 10'b100001_0111: is_special = 1'b1;
            default:                          is_special = 1'b0;
        endcase
    endfunction

    state_t     state_r;
    state_t     next_s;
    logic [1:0] good_cgs_r;
    logic [1:0] good_next_s;
    logic       even_next_s;
    logic       status_next_s;
    logic       comma_s;
    logic       data_s;
    logic       cgbad_s;
    logic       at_limit_s;

    assign comma_s    = is_comma(rx_code_group);
    assign data_s     = is_data(rx_code_group);
    assign cgbad_s    = !(data_s || is_special(rx_code_group)) || (comma_s && rx_even);
    assign at_limit_s = (good_cgs_r == LIMIT);

    // Next-state selection; loss of signal overrides every transition.
    always_comb begin
        next_s = LOSS_OF_SYNC;
        if (!signal_detect) begin
            next_s = LOSS_OF_SYNC;
        end else begin
            case (state_r)
                LOSS_OF_SYNC:     next_s = comma_s ? COMMA_DETECT_1 : LOSS_OF_SYNC;
                COMMA_DETECT_1:   next_s = data_s ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
                COMMA_DETECT_2:   next_s = data_s ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
                COMMA_DETECT_3:   next_s = data_s ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
                ACQUIRE_SYNC_1:   next_s = cgbad_s ? LOSS_OF_SYNC :
                                           (comma_s ? COMMA_DETECT_2 : ACQUIRE_SYNC_1);
                ACQUIRE_SYNC_2:   next_s = cgbad_s ? LOSS_OF_SYNC :
                                           (comma_s ? COMMA_DETECT_3 : ACQUIRE_SYNC_2);
                SYNC_ACQUIRED_1:  next_s = cgbad_s ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
                SYNC_ACQUIRED_2:  next_s = cgbad_s ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
                SYNC_ACQUIRED_3:  next_s = cgbad_s ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
                SYNC_ACQUIRED_4:  next_s = cgbad_s ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
                SYNC_ACQUIRED_2A: next_s = cgbad_s ? SYNC_ACQUIRED_3 :
                                           (at_limit_s ? SYNC_ACQUIRED_1 : SYNC_ACQUIRED_2A);
                SYNC_ACQUIRED_3A: next_s = cgbad_s ? SYNC_ACQUIRED_4 :
                                           (at_limit_s ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3A);
                SYNC_ACQUIRED_4A: next_s = cgbad_s ? LOSS_OF_SYNC :
                                           (at_limit_s ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_4A);
                default:          next_s = LOSS_OF_SYNC;
            endcase
        end
    end

    // Side values derived from the chosen next state.
    always_comb begin
        good_next_s   = 2'd0;
        even_next_s   = ~rx_even;
        status_next_s = 1'b0;
        case (next_s)
            COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3: begin
                even_next_s = 1'b1;
            end
            SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                status_next_s = 1'b1;
            end
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
                status_next_s = 1'b1;
                good_next_s   = at_limit_s ? LIMIT : good_cgs_r + 2'd1;
            end
            default: begin
                good_next_s = 2'd0;
            end
        endcase
    end

    // State, counter and all outputs registered together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= LOSS_OF_SYNC;
            good_cgs_r  <= 2'd0;
            rx_even     <= 1'b0;
            sync_status <= 1'b0;
            sync_state  <= 13'b0_0000_0000_0001;
            cg_out      <= 10'h000;
        end else begin
            state_r     <= next_s;
            good_cgs_r  <= good_next_s;
            rx_even     <= even_next_s;
            sync_status <= status_next_s;
            sync_state  <= 13'b0_0000_0000_0001 << next_s;
            cg_out      <= rx_code_group;
        end
    end

endmodule

// File: tb/tb_pcs_sync.sv
// Self-checking bench for pcs_sync: directed acquisition/loss scenarios followed by
// randomized code-group streams compared against a level-based behavioural model.
module tb_pcs_sync;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        signal_detect;
    logic [9:0]  rx_code_group;
    logic [9:0]  cg_out;
    logic        sync_status;
    logic        rx_even;
    logic [12:0] sync_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcs_sync #(.GOOD_CGS_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .signal_detect (signal_detect),
        .rx_code_group (rx_code_group),
        .cg_out        (cg_out),
        .sync_status   (sync_status),
        .rx_even       (rx_even),
        .sync_state    (sync_state)
    );

    logic [9:0] data_tab [17] = '{
        10'b100111_0100, 10'b011000_1011, 10'b011101_0100, 10'b100010_1011,
        10'b101101_0100, 10'b010010_1011, 10'b110001_1011, 10'b110001_0100,
        10'b101101_0101, 10'b010010_0101, 10'b011011_0101, 10'b100100_0101,
        10'b010110_1101, 10'b010110_0010, 10'b011001_1010, 10'b101010_1010,
        10'b101001_0110};
    logic [9:0] k_tab [24] = '{
        10'b001111_0100, 10'b110000_1011, 10'b001111_1001, 10'b110000_0110,
        10'b001111_0101, 10'b110000_1010, 10'b001111_0011, 10'b110000_1100,
        10'b001111_0010, 10'b110000_1101, 10'b001111_1010, 10'b110000_0101,
        10'b001111_0110, 10'b110000_1001, 10'b001111_1000, 10'b110000_0111,
        10'b111010_1000, 10'b000101_0111, 10'b110110_1000, 10'b001001_0111,
        10'b101110_1000, 10'b010001_0111, 10'b011110_1000, 10'b100001_0111};
    logic [9:0] comma_tab [6] = '{
        10'b001111_1001, 10'b110000_0110, 10'b001111_1010,
        10'b110000_0101, 10'b001111_1000, 10'b110000_0111};

    localparam logic [9:0] K285 = 10'b001111_1010;
    localparam logic [9:0] D162 = 10'b011011_0101;
    localparam logic [9:0] BAD  = 10'h000;

    // Reference model: sync level 0 = acquiring, 1..4 = SYNC_ACQUIRED level.
    int         m_lvl, m_cc, m_good;
    bit         m_wd, m_sub, m_ev;
    logic [9:0] m_prev;

    function automatic bit in_tab_data(input logic [9:0] cg);
        foreach (data_tab[i]) if (data_tab[i] == cg) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_tab_k(input logic [9:0] cg);
        foreach (k_tab[i]) if (k_tab[i] == cg) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_tab_comma(input logic [9:0] cg);
        foreach (comma_tab[i]) if (comma_tab[i] == cg) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_los();
        m_lvl = 0; m_cc = 0; m_wd = 1'b0; m_sub = 1'b0; m_good = 0;
    endtask

    task automatic m_step(input bit rstn, input bit sd, input logic [9:0] cg);
        bit v, c, d, bad;
        if (!rstn) begin
            m_los();
            m_ev   = 1'b0;
            m_prev = 10'h000;
            return;
        end
        m_prev = cg;
        d   = in_tab_data(cg);
        c   = in_tab_comma(cg);
        v   = d || in_tab_k(cg);
        bad = !v || (c && m_ev);
        if (!sd) begin
            m_los();
        end else if (m_lvl == 0) begin
            if (m_cc == 0) begin
                if (c) begin m_cc = 1; m_wd = 1'b1; end
            end else if (m_wd) begin
                if (!d) m_los();
                else if (m_cc == 3) begin m_los(); m_lvl = 1; end
                else m_wd = 1'b0;
            end else begin
                if (bad) m_los();
                else if (c) begin m_cc++; m_wd = 1'b1; end
            end
        end else begin
            if (bad) begin
                if (m_lvl == 4) m_los();
                else begin m_lvl++; m_sub = 1'b0; m_good = 0; end
            end else if (m_lvl > 1) begin
                if (!m_sub) begin m_sub = 1'b1; m_good = 1; end
                else if (m_good == LIMIT) begin m_lvl--; m_sub = 1'b0; m_good = 0; end
                else m_good++;
            end
        end
        m_ev = (m_lvl == 0 && m_cc > 0 && m_wd) ? 1'b1 : !m_ev;
    endtask

    function automatic int m_idx();
        if (m_lvl == 0) return (m_cc == 0) ? 0 : (m_wd ? 2 * m_cc - 1 : 2 * m_cc);
        if (m_lvl == 1) return 6;
        return m_sub ? 2 * m_lvl + 4 : 2 * m_lvl + 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rstn, input bit sd, input logic [9:0] cg);
        logic [12:0] e;
        reset_n       = rstn;
        signal_detect = sd;
        rx_code_group = cg;
        @(posedge clk);
        m_step(rstn, sd, cg);
        #1;
        e = 13'd0;
        e[m_idx()] = 1'b1;
        check_eq("sync_state",  32'(sync_state),  32'(e));
        check_eq("sync_status", 32'(sync_status), 32'(m_lvl > 0));
        check_eq("rx_even",     32'(rx_even),     32'(m_ev));
        check_eq("cg_out",      32'(cg_out),      32'(m_prev));
    endtask

    task automatic acquire();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, K285);
            step(1'b1, 1'b1, D162);
        end
    endtask

    initial begin
        logic [9:0] cg;
        bit         sd, rstn;
        int         r;
        reset_n = 1'b0; signal_detect = 1'b1; rx_code_group = 10'h000;

        step(1'b0, 1'b1, 10'($urandom));
        step(1'b0, 1'b0, 10'($urandom));
        check_eq("reset_state", 32'(sync_state), 32'h1);
        check_eq("reset_cg",    32'(cg_out),     32'h0);

        acquire();
        check_eq("acq_state",  32'(sync_state),  32'h40);
        check_eq("acq_status", 32'(sync_status), 32'h1);

        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, BAD);
        check_eq("loss_state",  32'(sync_state),  32'h1);
        check_eq("loss_status", 32'(sync_status), 32'h0);

        acquire();
        step(1'b1, 1'b1, BAD);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, D162);
        check_eq("recover_state", 32'(sync_state), 32'h40);

        step(1'b1, 1'b0, D162);
        check_eq("sd_loss_state", 32'(sync_state), 32'h1);

        step(1'b1, 1'b1, K285);
        step(1'b1, 1'b1, D162);
        step(1'b1, 1'b1, D162);
        check_eq("odd_in_acq", 32'(rx_even), 32'h1);
        step(1'b1, 1'b1, K285);
        check_eq("odd_comma_loss", 32'(sync_state), 32'h1);

        acquire();
        step(1'b0, 1'b1, D162);
        check_eq("mid_reset_state", 32'(sync_state), 32'h1);
        check_eq("mid_reset_even",  32'(rx_even),    32'h0);

        for (int n = 0; n < 4000; n++) begin
            rstn = ($urandom_range(0, 399) != 0);
            sd   = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 3) != 0) begin
                if (m_ev || $urandom_range(0, 2) != 0) cg = data_tab[$urandom_range(0, 16)];
                else cg = comma_tab[$urandom_range(0, 5)];
            end else begin
                r = $urandom_range(0, 99);
                if (r < 30)      cg = comma_tab[$urandom_range(0, 5)];
                else if (r < 60) cg = data_tab[$urandom_range(0, 16)];
                else if (r < 80) cg = k_tab[$urandom_range(0, 23)];
                else if (r < 90) cg = BAD;
                else             cg = 10'($urandom);
            end
            step(rstn, sd, cg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
